// File: rtl/delay_arb_pkg.sv
// delay_arb_pkg: shared types and constants for the delay line arbiter.
//   state_t     : arbiter FSM states
//   TMO_MARGIN  : extra WAIT cycles allowed beyond the programmed tap
//   DELAY_W_DEF : default tap width (matches the delay line's delay port)
package delay_arb_pkg;
  localparam int DELAY_W_DEF = 3;
  localparam int TMO_MARGIN  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/delay_line_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority index this round
//   win_oh  : one-hot winner (zero when no request)
//   win_idx : winner index
//   any     : at least one request present
// Scans indices ptr, ptr+1, ... wrapping at N_REQ; first set bit wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);
  logic [IDX_W:0] j;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // one spare bit so ptr+k cannot wrap before the modulo fold
      j = {1'b0, ptr} + (IDX_W+1)'(k);
      if (j >= (IDX_W+1)'(N_REQ)) j = j - (IDX_W+1)'(N_REQ);
      if (!any && req[j[IDX_W-1:0]]) begin
        any                  = 1'b1;
        win_idx              = j[IDX_W-1:0];
        win_oh[j[IDX_W-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/delay_line_arbiter.sv
// delay_line_arbiter: shares one programmable delay line among N_REQ
// requesters. Grants one request at a time (round robin), programs the
// line's tap from the winner, launches a one-cycle din pulse, waits for the
// echo on dout, then pulses done for the winner.
//
// Ports:
//   clk, reset      : clock, async active-low reset
//   req             : per-requester request level (held until gnt)
//   req_delay       : packed taps, slice i = [i*DELAY_W +: DELAY_W]
//   gnt, done       : one-hot, one-cycle grant / completion pulses
//   timeout_err     : with done when the echo never arrived
//   busy            : grant cycle through done cycle
//   dl_delay,dl_din : to delay line;  dl_dout : from delay line
//
// Build option: DELAY_ARB_TIMEOUT_EN enables the WAIT watchdog. Without it
// WAIT only exits on an echo and timeout_err is tied low.
module delay_line_arbiter
  import delay_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DELAY_W-1:0]   req_delay,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic                       timeout_err,
  output logic                       busy,
  output logic [DELAY_W-1:0]         dl_delay,
  output logic                       dl_din,
  input  logic                       dl_dout
);
  localparam int IDX_W = $clog2(N_REQ);
  // two extra bits keep tap + margin from overflowing the compare
  localparam int CNT_W = DELAY_W + 2;

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                ptr, ptr_nxt, win, win_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic [N_REQ-1:0]                gnt_nxt, done_nxt;
  logic [DELAY_W-1:0]              dly_nxt;
  logic                            din_nxt, busy_nxt;
  logic [N_REQ-1:0][DELAY_W-1:0]   tap;
  logic [N_REQ-1:0]                pick_oh;
  logic [IDX_W-1:0]                pick_idx;
  logic                            pick_any;

  assign tap = req_delay;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

`ifdef DELAY_ARB_TIMEOUT_EN
  logic             tmo_nxt;
  logic [CNT_W-1:0] limit;
  assign limit = CNT_W'(dl_delay) + CNT_W'(TMO_MARGIN);
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    win_nxt   = win;
    cnt_nxt   = cnt;
    dly_nxt   = dl_delay;
    busy_nxt  = busy;
    gnt_nxt   = '0;
    done_nxt  = '0;
    din_nxt   = 1'b0;
`ifdef DELAY_ARB_TIMEOUT_EN
    tmo_nxt   = 1'b0;
`endif
    case (state)
      IDLE: if (pick_any) begin
        state_nxt = LAUNCH;
        gnt_nxt   = pick_oh;
        din_nxt   = 1'b1;
        dly_nxt   = tap[pick_idx];   // only sample point for the tap
        win_nxt   = pick_idx;
        busy_nxt  = 1'b1;
      end
      LAUNCH: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (dl_dout) begin
          state_nxt     = DONE;
          done_nxt[win] = 1'b1;
        end
`ifdef DELAY_ARB_TIMEOUT_EN
        // exit after exactly tap+margin silent WAIT cycles
        else if (cnt + CNT_W'(1) == limit) begin
          state_nxt     = DONE;
          done_nxt[win] = 1'b1;
          tmo_nxt       = 1'b1;
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        ptr_nxt   = (win == IDX_W'(N_REQ-1)) ? '0 : win + IDX_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      dl_delay <= '0;
      dl_din   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      win      <= win_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
      dl_delay <= dly_nxt;
      dl_din   <= din_nxt;
    end
  end

`ifdef DELAY_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout_err <= 1'b0;
    else        timeout_err <= tmo_nxt;
  end
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_delay_line_arbiter.sv
// Directed bench for delay_line_arbiter. A behavioural delay line echoes
// din on dout delay+1 cycles later; 'stuck' forces dout low.
module tb_delay_line_arbiter;
  localparam int N  = 4;
  localparam int DW = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0][DW-1:0] rd = '0;
  logic [N-1:0]        gnt, done;
  logic                timeout_err, busy, dl_din, dl_dout;
  logic [DW-1:0]       dl_delay;
  logic                stuck = 1'b0;
  logic [7:0]          sr;
  logic [N-1:0]        acc_a, acc_b;
  int                  n_vec = 0;
  int                  n_err = 0;

  always #5 clk = ~clk;

  delay_line_arbiter #(.N_REQ(N), .DELAY_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_delay   (rd),
    .gnt         (gnt),
    .done        (done),
    .timeout_err (timeout_err),
    .busy        (busy),
    .dl_delay    (dl_delay),
    .dl_din      (dl_din),
    .dl_dout     (dl_dout)
  );

  // delay line model: sr[k] holds din from k+1 cycles ago
  always_ff @(posedge clk or negedge reset)
    if (!reset) sr <= '0;
    else        sr <= {sr[6:0], dl_din};
  assign dl_dout = stuck ? 1'b0 : sr[dl_delay];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    step; step;
    reset = 1'b1;
    step;
  endtask

  initial begin
    // reset values
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_dly", dl_delay, 0);
    chk("rst_din", dl_din, 0);
    do_reset;

    // single request, tap 5: gnt T0+1, done T0+8
    rd[0] = 3'd5; req = 4'b0001;
    step;
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_din", dl_din, 1);
    chk("t1_busy", busy, 1);
    chk("t1_dly", dl_delay, 5);
    req = '0;
    for (int t = 2; t <= 7; t++) begin
      step;
      chk("t1_nodone", done, 0);
      chk("t1_dly_hold", dl_delay, 5);
      chk("t1_din_low", dl_din, 0);
    end
    step;
    chk("t1_done", done, 4'b0001);
    chk("t1_tmo", timeout_err, 0);
    chk("t1_dly_done", dl_delay, 5);
    step;
    chk("t1_idle", busy, 0);
    chk("t1_done_clr", done, 0);

    // all requesting, tap 3: grants 0,1,2,3,0 every 7 cycles
    do_reset;
    rd = {3'd3, 3'd3, 3'd3, 3'd3}; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step;
      chk("rr_gnt", gnt, 32'(1) << (g % 4));
      for (int s = 2; s <= 5; s++) begin
        step;
        chk("rr_nodone", done, 0);
        chk("rr_nognt", gnt, 0);
        chk("rr_busy", busy, 1);
      end
      step;
      chk("rr_done", done, 32'(1) << (g % 4));
      step;
      chk("rr_gap", busy, 0);
    end
    req = '0;

    // tap change during WAIT has no effect
    do_reset;
    rd[1] = 3'd7; req = 4'b0010;
    step;
    chk("t3_gnt", gnt, 4'b0010);
    chk("t3_dly", dl_delay, 7);
    req = '0;
    for (int t = 2; t <= 9; t++) begin
      step;
      if (t == 2) rd[1] = 3'd2;
      chk("t3_dly_hold", dl_delay, 7);
      chk("t3_nodone", done, 0);
    end
    step;
    chk("t3_done", done, 4'b0010);
    chk("t3_dly_done", dl_delay, 7);
    step;
    chk("t3_dly_idle", dl_delay, 7);
    chk("t3_idle", busy, 0);

    // echo never arrives, tap 2
    do_reset;
    rd[0] = 3'd2; stuck = 1'b1; req = 4'b0001;
    step;
    chk("t4_gnt", gnt, 4'b0001);
    req = '0;
`ifdef DELAY_ARB_TIMEOUT_EN
    for (int t = 2; t <= 6; t++) begin
      step;
      chk("t4_nodone", done, 0);
      chk("t4_notmo", timeout_err, 0);
    end
    step;
    chk("t4_done", done, 4'b0001);
    chk("t4_tmo", timeout_err, 1);
    step;
    chk("t4_idle", busy, 0);
    chk("t4_tmo_clr", timeout_err, 0);
    chk("t4_done_clr", done, 0);
`else
    for (int t = 0; t < 30; t++) begin
      step;
      chk("t4_hang_busy", busy, 1);
      chk("t4_hang_nodone", done, 0);
      chk("t4_hang_tmo", timeout_err, 0);
    end
`endif
    stuck = 1'b0;

    // async reset during WAIT
    do_reset;
    rd[0] = 3'd7; req = 4'b0001;
    step;
    chk("t5_gnt", gnt, 4'b0001);
    req = '0;
    step; step; step;
    chk("t5_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    chk("t5_gnt0", gnt, 0);
    chk("t5_done0", done, 0);
    chk("t5_busy0", busy, 0);
    chk("t5_dly0", dl_delay, 0);
    chk("t5_din0", dl_din, 0);
    chk("t5_tmo0", timeout_err, 0);
    step; step;
    reset = 1'b1;
    acc_a = '0;
    for (int t = 0; t < 12; t++) begin
      step;
      acc_a |= done;
    end
    chk("t5_no_done", acc_a, 0);
    rd[2] = 3'd4; req = 4'b0100;
    step;
    chk("t5_gnt2", gnt, 4'b0100);
    chk("t5_dly2", dl_delay, 4);
    req = '0;
    for (int t = 2; t <= 6; t++) step;
    step;
    chk("t5_done2", done, 4'b0100);

    // one-cycle req pulse while busy is lost
    do_reset;
    rd[0] = 3'd1; rd[2] = 3'd1; req = 4'b0001;
    step;
    chk("t6_gnt", gnt, 4'b0001);
    req = 4'b0100;
    step;
    req = '0;
    acc_a = '0; acc_b = '0;
    for (int t = 0; t < 15; t++) begin
      step;
      acc_a |= gnt;
      acc_b |= done;
    end
    chk("t6_no_gnt2", acc_a, 0);
    chk("t6_done0", acc_b, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
